load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning the maximum number of cycles waited for bus_gnt or bus_rvalid before an error is flagged.
REQ-002 clk  in  1  clock; all state changes on rising edge.
REQ-003 rstn  in  1  reset; asynchronous, active-low.
REQ-004 dmem_rd  in  1  load strobe from the control unit.
REQ-005 dmem_we  in  4  store strobe from the control unit; any nonzero value means store.
REQ-006 funct3  in  3  access size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; for stores 000 SB, 001 SH, 010 SW.
REQ-007 addr  in  32  byte address from the ALU.
REQ-008 wdata  in  32  store data, right-aligned (rs2).
REQ-009 bus_req  out  1  bus request valid.
REQ-010 bus_we  out  4  byte-lane write enables; 0000 on loads.
REQ-011 bus_addr  out  32  word address: {addr[31:2],2'b00}.
REQ-012 bus_wdata  out  32  lane-shifted store data.
REQ-013 bus_gnt  in  1  bus accepts the request this cycle.
REQ-014 bus_rvalid  in  1  read data valid.
REQ-015 bus_rdata  in  32  read word.
REQ-016 load_data  out  32  aligned, extended load result, held until the next load completes.
REQ-017 busy  out  1  transaction in progress (stall request to control).
REQ-018 done  out  1  one-cycle pulse on completion, including stores.
REQ-019 err  out  1  one-cycle pulse on misalignment or timeout.

Function
REQ-020 FSM states SHALL be IDLE, REQ, RWAIT and RESP.
REQ-021 IDLE: on dmem_rd or |dmem_we, SHALL latch addr, funct3, wdata and the op, then go to REQ; if both strobes are set, the store SHALL win.
REQ-022 Misaligned accesses SHALL pulse err in the cycle after the strobe, issue no bus_req and stay in IDLE. Misaligned means halfword with addr[0]=1, or word with addr[1:0]!=0.
REQ-023 REQ: bus_req=1 with stable bus_addr, bus_we and bus_wdata until bus_gnt.
  - Store gnt SHALL go to RESP.
  - Load gnt SHALL go to RWAIT.
REQ-024 RWAIT: on bus_rvalid, SHALL extract the addressed byte or halfword from bus_rdata, extend it per funct3, register it into load_data and go to RESP; bus_rvalid in the gnt cycle SHALL NOT be sampled.
REQ-025 RESP: SHALL pulse done for one cycle and return to IDLE.
REQ-026 Store lanes SHALL be:
  - SB: bus_we = 0001 << addr[1:0], wdata[7:0] replicated in all four bytes.
  - SH: bus_we = 0011 << addr[1:0], wdata[15:0] replicated in both halves.
  - SW: bus_we = 1111.
REQ-027 busy SHALL be 1 in REQ, RWAIT and RESP, and 0 in IDLE.
REQ-028 A wait counter SHALL clear on entry to REQ and RWAIT and increment each cycle there. When it reaches TIMEOUT-1 without the awaited handshake, the unit SHALL pulse err, drop bus_req, return to IDLE and leave load_data unchanged.
REQ-029 New strobes while busy SHALL be ignored.
REQ-030 Unsupported funct3 (011, 110, 111) SHALL be treated as misaligned (err, no access).

Reset
REQ-031 On rstn low, SHALL go to IDLE immediately, with bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, load_data=0, busy=0, done=0, err=0 and counter=0.
REQ-032 Reset mid-transaction SHALL abandon the transaction without a done or err pulse.

Structure
REQ-033 State encodings and funct3 size/sign constants SHALL live in the shared defines package.
REQ-034 Load alignment and extension SHALL be a combinational sub-module named load_align.

Verification
REQ-035 LW at addr 0x100, gnt after 2 cycles, rvalid 1 cycle later with 0xDEADBEEF -> load_data=0xDEADBEEF, one done pulse, busy high 5 cycles.
REQ-036 LB at 0x103 with rdata 0x80FFFFFF -> load_data=0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-037 SH at 0x102, wdata 0x1234ABCD, immediate gnt -> bus_we=1100, bus_wdata=0xABCDABCD, done 1 cycle after gnt.
REQ-038 LW at 0x101 -> err pulse, bus_req never asserted, busy stays 0.
REQ-039 LW with bus_gnt held low -> err after 16 cycles in REQ, then IDLE with load_data unchanged.
REQ-040 Reset asserted during RWAIT -> all outputs 0 at once, no done pulse; a fresh LW after reset completes normally.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: FSM states, funct3 access codes and access legality check
package load_store_unit_pkg;
  typedef enum logic [1:0] {IDLE, REQ, RWAIT, RESP} state_e;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  function automatic logic bad_access(input logic [2:0] f3, input logic [1:0] a);
    return (f3 inside {F3_H, F3_HU}) ? a[0] :
           (f3 == F3_W) ? (a != 2'b00) :
           !(f3 inside {F3_B, F3_BU});
  endfunction
endpackage

// File: rtl/load_align.sv
// load_align: selects the addressed byte/halfword of a read word and extends it per funct3
module load_align
  import load_store_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);
  logic [15:0] sh;
  always_comb begin
    sh = 16'(rdata >> {off, 3'b000});
    data = (funct3 == F3_B)  ? {{24{sh[7]}}, sh[7:0]} :
           (funct3 == F3_BU) ? {24'h0, sh[7:0]} :
           (funct3 == F3_H)  ? {{16{sh[15]}}, sh[15:0]} :
           (funct3 == F3_HU) ? {16'h0, sh[15:0]} : rdata;
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding data memory access FSM with lane steering and timeouts
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        dmem_rd,
  input  logic [3:0]  dmem_we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        bus_req,
  output logic [3:0]  bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  output logic [31:0] load_data,
  output logic        busy,
  output logic        done,
  output logic        err
);
  localparam int CW = $clog2(TIMEOUT) + 1;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, load_data_q, load_data_d, aligned;
  logic [3:0] we_q, we_d;
  logic [2:0] f3_q, f3_d;
  logic [1:0] off_q, off_d;
  logic err_q, err_d, st, go, tmo;
  load_align u_align (.rdata(bus_rdata), .off(off_q), .funct3(f3_q), .data(aligned));
  always_comb begin
    st = |dmem_we;
    go = dmem_rd | st;
    tmo = cnt_q == CW'(TIMEOUT - 1);
    state_d = state_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    load_data_d = load_data_q;
    we_d = we_q;
    f3_d = f3_q;
    off_d = off_q;
    err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (go && bad_access(funct3, addr[1:0])) err_d = 1'b1;
        else if (go) begin
          state_d = REQ;
          cnt_d = '0;
          addr_d = {addr[31:2], 2'b00};
          off_d = addr[1:0];
          f3_d = funct3;
          we_d = !st ? 4'h0 : funct3[1] ? 4'hF : funct3[0] ? 4'b0011 << addr[1:0] : 4'b0001 << addr[1:0];
          wdata_d = funct3[1] ? wdata : funct3[0] ? {2{wdata[15:0]}} : {4{wdata[7:0]}};
        end
      end
      REQ: begin
        state_d = bus_gnt ? (|we_q ? RESP : RWAIT) : tmo ? IDLE : REQ;
        cnt_d = bus_gnt ? '0 : cnt_q + 1'b1;
        err_d = !bus_gnt && tmo;
      end
      RWAIT: begin
        state_d = bus_rvalid ? RESP : tmo ? IDLE : RWAIT;
        cnt_d = cnt_q + 1'b1;
        err_d = !bus_rvalid && tmo;
        load_data_d = bus_rvalid ? aligned : load_data_q;
      end
      RESP: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      load_data_q <= '0;
      we_q <= '0;
      f3_q <= '0;
      off_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      load_data_q <= load_data_d;
      we_q <= we_d;
      f3_q <= f3_d;
      off_q <= off_d;
      err_q <= err_d;
    end
  end
  assign bus_req = state_q == REQ;
  assign bus_we = we_q;
  assign bus_addr = addr_q;
  assign bus_wdata = wdata_q;
  assign load_data = load_data_q;
  assign busy = state_q != IDLE;
  assign done = state_q == RESP;
  assign err = err_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized and directed checks of load_store_unit against a byte-level reference model
module tb_load_store_unit;
  localparam int TO = 16;
  logic clk = 1'b0, rstn = 1'b1, dmem_rd = 1'b0, bus_gnt = 1'b0, bus_rvalid = 1'b0;
  logic [3:0] dmem_we = '0;
  logic [2:0] funct3 = '0;
  logic [31:0] addr = '0, wdata = '0, bus_rdata = '0;
  logic bus_req, busy, done, err;
  logic [3:0] bus_we;
  logic [31:0] bus_addr, bus_wdata, load_data;
  int tests = 0, fails = 0;
  logic [31:0] exp_ld = '0;

  load_store_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn), .dmem_rd(dmem_rd), .dmem_we(dmem_we), .funct3(funct3),
    .addr(addr), .wdata(wdata), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
    .load_data(load_data), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic int size_of(input logic [2:0] f3);
    return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] w);
    int sz;
    longint v;
    sz = size_of(f3);
    v = longint'(w >> (8 * off)) & ((longint'(1) << (8 * sz)) - 1);
    if (!f3[2] && sz < 4 && v >= (longint'(1) << (8 * sz - 1))) v = v - (longint'(1) << (8 * sz));
    return v[31:0];
  endfunction

  function automatic logic [3:0] ref_we(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[i] = (i >= int'(off)) && (i < int'(off) + size_of(f3));
    return r;
  endfunction

  function automatic logic [31:0] ref_wd(input logic [2:0] f3, input logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(i % size_of(f3)) +: 8];
    return r;
  endfunction

  task automatic junk_strobes();
    dmem_rd = 1'($urandom);
    dmem_we = 4'($urandom);
    funct3 = 3'($urandom);
    addr = $urandom;
    wdata = $urandom;
  endtask

  task automatic run_op(input bit st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input int gd, input int rdly, input bit both);
    int busy_n;
    logic [31:0] ea, ewd;
    logic [3:0] ewe;
    ea = {a[31:2], 2'b00};
    ewe = st ? ref_we(f3, a[1:0]) : 4'h0;
    ewd = ref_wd(f3, wd);
    busy_n = 0;
    @(negedge clk);
    dmem_rd = !st || both;
    dmem_we = st ? 4'($urandom_range(1, 15)) : 4'h0;
    funct3 = f3;
    addr = a;
    wdata = wd;
    @(negedge clk);
    for (int n = 0; n <= gd; n++) begin
      junk_strobes();
      tests++;
      if (bus_req !== 1'b1 || bus_addr !== ea || bus_we !== ewe || (st && bus_wdata !== ewd) || done !== 1'b0 || busy !== 1'b1) begin
        fails++;
        $display("FAIL req_phase: req=%b addr=%h we=%b wdata=%h done=%b busy=%b, expected req=1 addr=%h we=%b wdata=%h done=0 busy=1",
                 bus_req, bus_addr, bus_we, bus_wdata, done, busy, ea, ewe, ewd);
      end
      busy_n += busy;
      bus_gnt = (n == gd);
      bus_rvalid = (n == gd) && !st;
      bus_rdata = $urandom;
      @(negedge clk);
    end
    bus_gnt = 1'b0;
    bus_rvalid = 1'b0;
    if (!st) for (int m = 0; m <= rdly; m++) begin
      junk_strobes();
      tests++;
      if (bus_req !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
        fails++;
        $display("FAIL rwait_phase: req=%b busy=%b done=%b, expected req=0 busy=1 done=0", bus_req, busy, done);
      end
      busy_n += busy;
      bus_rvalid = (m == rdly);
      bus_rdata = (m == rdly) ? rd : $urandom;
      @(negedge clk);
    end
    bus_rvalid = 1'b0;
    if (!st) exp_ld = ref_load(f3, a[1:0], rd);
    dmem_rd = 1'b0;
    dmem_we = 4'h0;
    tests++;
    if (done !== 1'b1 || busy !== 1'b1 || err !== 1'b0 || load_data !== exp_ld) begin
      fails++;
      $display("FAIL resp_phase: done=%b busy=%b err=%b load_data=%h, expected done=1 busy=1 err=0 load_data=%h",
               done, busy, err, load_data, exp_ld);
    end
    busy_n += busy;
    @(negedge clk);
    tests++;
    if (done !== 1'b0 || busy !== 1'b0 || bus_req !== 1'b0 || err !== 1'b0 || busy_n != (st ? gd + 2 : gd + rdly + 3)) begin
      fails++;
      $display("FAIL after_done: done=%b busy=%b req=%b err=%b busy_cycles=%0d, expected 0 0 0 0 busy_cycles=%0d",
               done, busy, bus_req, err, busy_n, st ? gd + 2 : gd + rdly + 3);
    end
  endtask

  task automatic check_all_zero(input string name);
    tests++;
    if (bus_req !== 1'b0 || bus_we !== 4'h0 || bus_addr !== 32'h0 || bus_wdata !== 32'h0 ||
        load_data !== 32'h0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      fails++;
      $display("FAIL %s: req=%b we=%b addr=%h wdata=%h ld=%h busy=%b done=%b err=%b, expected all zero",
               name, bus_req, bus_we, bus_addr, bus_wdata, load_data, busy, done, err);
    end
  endtask

  task automatic test_reset();
    #1 rstn = 1'b0;
    #2 check_all_zero("reset_state");
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    exp_ld = '0;
  endtask

  task automatic test_lw();
    run_op(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 2, 0, 1'b0);
    tests++;
    if (load_data !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL lw_value: load_data=%h, expected deadbeef", load_data);
    end
  endtask

  task automatic test_lb_lbu();
    run_op(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FFFFFF, 0, 1, 1'b0);
    tests++;
    if (load_data !== 32'hFFFFFF80) begin
      fails++;
      $display("FAIL lb_value: load_data=%h, expected ffffff80", load_data);
    end
    run_op(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FFFFFF, 1, 0, 1'b0);
    tests++;
    if (load_data !== 32'h00000080) begin
      fails++;
      $display("FAIL lbu_value: load_data=%h, expected 00000080", load_data);
    end
  endtask

  task automatic test_store();
    run_op(1'b1, 3'b001, 32'h102, 32'h1234ABCD, 32'h0, 0, 0, 1'b0);
    tests++;
    if (bus_we !== 4'b1100 || bus_wdata !== 32'hABCDABCD) begin
      fails++;
      $display("FAIL sh_lanes: we=%b wdata=%h, expected 1100 abcdabcd", bus_we, bus_wdata);
    end
    run_op(1'b1, 3'b000, 32'h201, 32'h000000A5, 32'h0, 1, 0, 1'b1);
    run_op(1'b1, 3'b010, 32'h300, 32'hCAFEF00D, 32'h0, 3, 0, 1'b1);
  endtask

  task automatic test_misaligned();
    logic [2:0] f3s [7] = '{3'b010, 3'b010, 3'b001, 3'b101, 3'b011, 3'b110, 3'b111};
    logic [31:0] as [7] = '{32'h101, 32'h102, 32'h103, 32'h201, 32'h100, 32'h100, 32'h0};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      dmem_rd = (i % 2) == 0;
      dmem_we = (i % 2) == 0 ? 4'h0 : 4'h3;
      funct3 = f3s[i];
      addr = as[i];
      wdata = $urandom;
      @(negedge clk);
      dmem_rd = 1'b0;
      dmem_we = 4'h0;
      tests++;
      if (err !== 1'b1 || busy !== 1'b0 || bus_req !== 1'b0 || load_data !== exp_ld) begin
        fails++;
        $display("FAIL misaligned_%0d: err=%b busy=%b req=%b ld=%h, expected err=1 busy=0 req=0 ld=%h",
                 i, err, busy, bus_req, load_data, exp_ld);
      end
      @(negedge clk);
      tests++;
      if (err !== 1'b0 || busy !== 1'b0 || bus_req !== 1'b0 || done !== 1'b0) begin
        fails++;
        $display("FAIL misaligned_after_%0d: err=%b busy=%b req=%b done=%b, expected all 0", i, err, busy, bus_req, done);
      end
    end
  endtask

  task automatic test_timeout(input bit in_rwait);
    int n;
    @(negedge clk);
    dmem_rd = 1'b1;
    funct3 = 3'b010;
    addr = 32'h440;
    @(negedge clk);
    dmem_rd = 1'b0;
    bus_gnt = in_rwait;
    n = 0;
    while (busy === 1'b1 && n < 3 * TO) begin
      tests++;
      if (err !== 1'b0 || done !== 1'b0) begin
        fails++;
        $display("FAIL timeout_wait: err=%b done=%b at cycle %0d, expected 0 0", err, done, n);
      end
      n++;
      @(negedge clk);
      bus_gnt = 1'b0;
    end
    tests++;
    if (n != TO + int'(in_rwait) || err !== 1'b1 || bus_req !== 1'b0 || load_data !== exp_ld) begin
      fails++;
      $display("FAIL timeout_%0d: busy_cycles=%0d err=%b req=%b ld=%h, expected %0d 1 0 %h",
               in_rwait, n, err, bus_req, load_data, TO + int'(in_rwait), exp_ld);
    end
    @(negedge clk);
    tests++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL timeout_after_%0d: err=%b busy=%b, expected 0 0", in_rwait, err, busy);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    dmem_rd = 1'b1;
    funct3 = 3'b010;
    addr = 32'h500;
    @(negedge clk);
    dmem_rd = 1'b0;
    bus_gnt = 1'b1;
    @(negedge clk);
    bus_gnt = 1'b0;
    rstn = 1'b0;
    exp_ld = '0;
    #1 check_all_zero("reset_mid");
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus_rvalid = 1'b1;
      bus_rdata = $urandom;
      check_all_zero("reset_hold");
    end
    bus_rvalid = 1'b0;
    rstn = 1'b1;
    @(negedge clk);
    check_all_zero("reset_release");
    run_op(1'b0, 3'b010, 32'h600, 32'h0, 32'h13579BDF, 1, 2, 1'b0);
  endtask

  task automatic test_random();
    logic [2:0] lf3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    for (int i = 0; i < 40; i++) begin
      bit st;
      logic [2:0] f3;
      logic [31:0] a;
      st = 1'($urandom_range(0, 1));
      f3 = st ? 3'($urandom_range(0, 2)) : lf3[$urandom_range(0, 4)];
      a = $urandom & ~32'(size_of(f3) - 1);
      run_op(st, f3, a, $urandom, $urandom, $urandom_range(0, 5), $urandom_range(0, 5), st && $urandom_range(0, 3) == 0);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_lb_lbu();
    test_store();
    test_misaligned();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
